// File: rtl/mccoy_param_core.sv
// mccoy_param_core -- parametrised streamed-instruction accumulator core.
//
// One 6-bit instruction executes per accepted handshake against an accumulator
// (ACC) and a register file R0..R(NREGS-1).
//
// Optional feature macro: MCCOY_MUL_EN. When defined, MUL (6'b111001) runs a
// DATA_W-cycle shift-add multiply of ACC x R0 that stalls the stream. When
// undefined, MUL is a NOP, busy is tied low and instr_ready is tied high.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   instr[5:0]   in   instruction word
//   instr_valid  in   instr is presented
//   instr_ready  out  core accepts an instruction this cycle (== !busy)
//   out          out  output latch written by OUT
//   out_valid    out  one-cycle pulse after each OUT
//   carry        out  carry / borrow / shift-out flag
//   zero         out  accumulator-is-zero flag
//   busy         out  multiply in progress
module mccoy_param_core #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              carry,
  output logic              zero,
  output logic              busy
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  logic              accept;
  logic [2:0]        rrr;
  logic              rrr_hit;   // rrr names an implemented register
  logic [DATA_W-1:0] rdata;
  logic [DATA_W:0]   sum;
  logic              acc_wr;    // ACC written this cycle -> refresh zero flag

`ifdef MCCOY_MUL_EN
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;   // R0 snapshot, shifted left per step
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [2*DATA_W-1:0] prod_step;
  logic [DATA_W-1:0]   mplier_q, mplier_d; // ACC snapshot, shifted right per step
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign busy = (state_q == ST_MUL);
`else
  assign busy = 1'b0;
`endif

  assign instr_ready = !busy;
  assign accept      = instr_valid && instr_ready;
  assign rrr         = instr[2:0];

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    acc_d       = acc_q;
    regs_d      = regs_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    carry_d     = carry_q;
    zero_d      = zero_q;
    acc_wr      = 1'b0;
    rdata       = '0;
    rrr_hit     = 1'b0;

    // Register read mux; an out-of-range index finds no match.
    for (int i = 0; i < NREGS; i++) begin
      if (rrr == 3'(i)) begin
        rdata   = regs_q[i];
        rrr_hit = 1'b1;
      end
    end
    sum = {1'b0, acc_q} + {1'b0, rdata};

`ifdef MCCOY_MUL_EN
    state_d   = state_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    if (state_q == ST_MUL) begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        acc_d   = prod_step[DATA_W-1:0];
        carry_d = |prod_step[2*DATA_W-1:DATA_W];
        acc_wr  = 1'b1;
        state_d = ST_IDLE;
      end
    end
`endif

    if (accept) begin
      casez (instr)
        6'b00????: begin                    // LDI
          acc_d   = DATA_W'(instr[3:0]);
          carry_d = 1'b0;
          acc_wr  = 1'b1;
        end
        6'b010???: begin                    // MOV
          for (int i = 0; i < NREGS; i++) begin
            if (rrr == 3'(i)) regs_d[i] = acc_q;
          end
        end
        6'b011???: if (rrr_hit) begin       // LD
          acc_d  = rdata;
          acc_wr = 1'b1;
        end
        6'b100???: if (rrr_hit) begin       // ADD
          {carry_d, acc_d} = sum;
          acc_wr = 1'b1;
        end
        6'b101???: if (rrr_hit) begin       // SUB
          acc_d   = acc_q - rdata;
          carry_d = (acc_q < rdata);
          acc_wr  = 1'b1;
        end
        6'b110???: if (rrr_hit) begin       // XOR
          acc_d   = acc_q ^ rdata;
          carry_d = 1'b0;
          acc_wr  = 1'b1;
        end
        6'b111000: begin                    // OUT
          out_d       = acc_q;
          out_valid_d = 1'b1;
        end
`ifdef MCCOY_MUL_EN
        6'b111001: begin                    // MUL: snapshot operands
          mcand_d  = {{DATA_W{1'b0}}, regs_q[0]};
          mplier_d = acc_q;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = ST_MUL;
        end
`endif
        6'b111010: begin                    // SHL
          carry_d = acc_q[DATA_W-1];
          acc_d   = acc_q << 1;
          acc_wr  = 1'b1;
        end
        6'b111011: begin                    // SHR
          carry_d = acc_q[0];
          acc_d   = acc_q >> 1;
          acc_wr  = 1'b1;
        end
        default: ;                          // NOP
      endcase
    end

    if (acc_wr) zero_d = (acc_d == '0);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      // NOTE: the register file is small and must read as zero after reset,
      // so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef MCCOY_MUL_EN
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      acc_q       <= acc_d;
      regs_q      <= regs_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
`ifdef MCCOY_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/mccoy_param_core.md
# mccoy_param_core

Parametrised successor to the McCoy 6-bit-instruction accumulator core. It executes one streamed instruction per accepted handshake against an accumulator and a small register file. Data width and register count are configurable, and an optional multi-cycle multiply stalls the instruction stream. It sits behind the TinyTapeout pin wrapper: `clk` and `reset` map to `io_in[7:6]`, `instr` to `io_in[5:0]`, and `out` drives `io_out`.

## Interface
- `DATA_W`, default 8: accumulator/register/output width. Legal range 4..16.
- `NREGS`, default 4: number of general registers R0..R(NREGS-1). Legal range 1..8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the next rising edge.
- `instr` in 6: instruction word.
- `instr_valid` in 1: `instr` is presented.
- `instr_ready` out 1: core can accept an instruction; equals `!busy`.
- `out` out DATA_W: output latch, written by OUT.
- `out_valid` out 1: one-cycle pulse, high the cycle after OUT executes.
- `carry` out 1: carry/borrow/shift-out flag.
- `zero` out 1: accumulator-is-zero flag.
- `busy` out 1: multiply in progress.

## Operation
- An instruction is accepted on a rising edge where `instr_valid && instr_ready`. It executes on that edge.
- Encoding (`rrr` = register index):
  - `00iiii` LDI: ACC <= zero-extended imm4. carry <= 0; zero updated.
  - `010rrr` MOV: Rr <= ACC. Flags unchanged.
  - `011rrr` LD: ACC <= Rr. zero updated; carry unchanged.
  - `100rrr` ADD: {carry, ACC} <= ACC + Rr, computed at DATA_W+1 bits.
  - `101rrr` SUB: ACC <= ACC - Rr, modulo 2^DATA_W. carry <= borrow (ACC < Rr).
  - `110rrr` XOR: ACC <= ACC ^ Rr. carry <= 0.
  - `111000` OUT: out <= ACC; out_valid pulses.
  - `111001` MUL: see Configuration.
  - `111010` SHL: carry <= ACC[MSB]; ACC <= ACC << 1.
  - `111011` SHR: carry <= ACC[0]; ACC <= ACC >> 1 (logical).
  - `111100`–`111111`: NOP.
- Every instruction that writes ACC sets zero <= (new ACC == 0). MOV, OUT and NOP leave both flags unchanged.
- If `rrr` >= NREGS, the instruction is a full NOP: no register, ACC or flag change.
- State machine: IDLE / MUL.
  - IDLE -> MUL on an accepted MUL (macro enabled only).
  - MUL -> IDLE after DATA_W iterations.
- Reset values: ACC, all Rr, out, out_valid, carry, zero, busy = 0; instr_ready = 1; state = IDLE.

## Timing
- Single-cycle instructions: accepted at edge t; results visible on outputs after edge t. Another instruction may be accepted at t+1.
- `out_valid`: high for exactly the one cycle following the OUT edge. Back-to-back OUTs hold it high continuously, and `out` updates each cycle.
- MUL accepted at edge t:
  - `busy`=1 and `instr_ready`=0 from after t through after t+DATA_W-1.
  - One shift-add step of ACC × R0 per cycle.
  - ACC takes the low DATA_W bits of the product at edge t+DATA_W.
  - carry <= 1 if any high product bit is nonzero, else 0; zero updated.
  - Ready again after edge t+DATA_W.
- R0 is snapshotted at acceptance.
- `instr_valid` held during busy is ignored and not consumed. The held instruction is accepted at the first edge with `instr_ready`=1.
- Reset asserted mid-MUL aborts it. All state is at reset values after that edge, regardless of `instr_valid`.
- Reset has priority over acceptance in the same cycle.

## Configuration
- `MCCOY_MUL_EN` defined: the MUL state, shift-add datapath and R0 snapshot are compiled in, with timing as above.
- `MCCOY_MUL_EN` undefined: `111001` is a NOP, `busy` is tied 0, `instr_ready` is tied 1, and no multiplier logic is present.

## Test plan
Bench uses DATA_W=8, NREGS=4.
- Add chain: reset; LDI 5, MOV R1, LDI 3, ADD R1, OUT -> out=0x08, out_valid high exactly 1 cycle, carry=0, zero=0.
- Subtract borrow: LDI 3, MOV R0, LDI 2, SUB R0 -> ACC=0xFF, carry=1, zero=0. Then XOR R0 -> ACC=0xFC, carry=0.
- Shift / zero: LDI 15, SHL ×4 -> ACC=0xF0, carry=0. SHL -> 0xE0, carry=1. SHR ×8 from 0x01 -> zero=1 after the first SHR, carry=1.
- Multiply (macro on): LDI 6, MOV R0, LDI 7, MUL, OUT with `instr_valid` held -> instr_ready low 8 cycles, then OUT accepted, out=0x2A, carry=0. 15 × 15 (R0 = 0x0F, ACC = 0x0F) -> 0xE1, carry=0. 0xF0 × 0x0F -> 0x10, carry=1.
- Reset mid-MUL: assert reset 3 cycles after MUL accept -> next cycle busy=0, instr_ready=1, ACC=0, out=0, all Rr=0.
- Out-of-range / macro off: MOV R5 and LD R6 with ACC=9 -> ACC and flags unchanged. With the macro undefined, MUL -> busy stays 0 and ACC unchanged.
